if_id_reg: RTL and testbench

- Pipeline register between the instruction fetch unit and the decode stage of the 5-stage MIPS core.
- Latches the fetched instruction and its PC+8 every cycle.
- Tags each slot with a fetch address exception (AdEL) and a branch-delay-slot (BD) flag for CP0.
- Holds on stall; inserts a bubble on interrupt/exception flush and on the slot following ERET.

---
 rtl/if_id_reg.sv | 105 ++++++++++
 tb/tb_if_id_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_reg.sv
// IF/ID pipeline register of the 5-stage MIPS core.
// Carries the fetched instruction and its PC+8 into decode, tags the slot
// with a fetch address error code and a branch-delay-slot flag for CP0,
// holds on stall and turns the slot into a bubble on flush or after ERET.
module if_id_reg #(
   parameter logic [31:0] PC_LO     = 32'h00003000,
   parameter logic [31:0] PC_HI     = 32'h00006FFC,
   parameter logic [4:0]  EXC_ADEL  = 5'd4,
   parameter logic [31:0] RESET_PC8 = 32'h00003008
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] instr_f,
   input  logic [31:0] pc8_f,
   input  logic        stall,
   input  logic        intreq,
   input  logic        eret_d,
   input  logic        branch_d,
   output logic [31:0] instr_d,
   output logic [31:0] pc8_d,
   output logic [31:0] pc_d,
   output logic [4:0]  exccode_d,
   output logic        bd_d,
   output logic        valid_d
);

   logic [31:0] instrReg_q, instrReg_d;
   logic [31:0] pc8Reg_q, pc8Reg_d;
   logic [4:0]  excReg_q, excReg_d;
   logic        bdReg_q, bdReg_d;
   logic        validReg_q, validReg_d;

   logic [31:0] pcF;
   logic        badF;

   // Recover the fetch PC and flag misaligned or out-of-range fetch addresses
   always_comb begin
      pcF  = pc8_f - 32'd8;
      badF = (pcF[1:0] != 2'b00) || (pcF < PC_LO) || (pcF > PC_HI);
   end

   // Next slot contents: flush beats stall, stall beats ERET bubble, else load
   always_comb begin
      instrReg_d = instrReg_q;
      pc8Reg_d   = pc8Reg_q;
      excReg_d   = excReg_q;
      bdReg_d    = bdReg_q;
      validReg_d = validReg_q;
      if (intreq) begin
         instrReg_d = 32'd0;
         pc8Reg_d   = pc8_f;
         excReg_d   = 5'd0;
         bdReg_d    = 1'b0;
         validReg_d = 1'b0;
      end else if (stall) begin
         instrReg_d = instrReg_q;
         pc8Reg_d   = pc8Reg_q;
         excReg_d   = excReg_q;
         bdReg_d    = bdReg_q;
         validReg_d = validReg_q;
      end else if (eret_d) begin
         instrReg_d = 32'd0;
         pc8Reg_d   = pc8_f;
         excReg_d   = 5'd0;
         bdReg_d    = 1'b0;
         validReg_d = 1'b0;
      end else begin
         pc8Reg_d   = pc8_f;
         bdReg_d    = branch_d;
         validReg_d = 1'b1;
         if (badF) begin
            instrReg_d = 32'd0;
            excReg_d   = EXC_ADEL;
         end else begin
            instrReg_d = instr_f;
            excReg_d   = 5'd0;
         end
      end
   end

   // Slot register, cleared asynchronously while clr is low
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         instrReg_q <= 32'd0;
         pc8Reg_q   <= RESET_PC8;
         excReg_q   <= 5'd0;
         bdReg_q    <= 1'b0;
         validReg_q <= 1'b0;
      end else begin
         instrReg_q <= instrReg_d;
         pc8Reg_q   <= pc8Reg_d;
         excReg_q   <= excReg_d;
         bdReg_q    <= bdReg_d;
         validReg_q <= validReg_d;
      end
   end

   assign instr_d   = instrReg_q;
   assign pc8_d     = pc8Reg_q;
   assign pc_d      = pc8Reg_q - 32'd8;
   assign exccode_d = excReg_q;
   assign bd_d      = bdReg_q;
   assign valid_d   = validReg_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: a reference model pushes the expected
// slot into a queue when stimulus is driven; it is popped and compared after
// the capturing edge.
module tb_if_id_reg;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc8;
      logic [4:0]  exc;
      logic        bd;
      logic        valid;
   } slot_t;

   logic        clk;
   logic        clr;
   logic [31:0] instr_f;
   logic [31:0] pc8_f;
   logic        stall;
   logic        intreq;
   logic        eret_d;
   logic        branch_d;
   logic [31:0] instr_d;
   logic [31:0] pc8_d;
   logic [31:0] pc_d;
   logic [4:0]  exccode_d;
   logic        bd_d;
   logic        valid_d;

   int checks = 0;
   int errors = 0;

   slot_t model;
   slot_t expQ[$];
   slot_t resetSlot;

   if_id_reg dut (
      .clk       (clk),
      .clr       (clr),
      .instr_f   (instr_f),
      .pc8_f     (pc8_f),
      .stall     (stall),
      .intreq    (intreq),
      .eret_d    (eret_d),
      .branch_d  (branch_d),
      .instr_d   (instr_d),
      .pc8_d     (pc8_d),
      .pc_d      (pc_d),
      .exccode_d (exccode_d),
      .bd_d      (bd_d),
      .valid_d   (valid_d)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkSlot(input string tag, input slot_t e);
      checkValue({tag, ".instr"}, instr_d, e.instr);
      checkValue({tag, ".pc8"}, pc8_d, e.pc8);
      checkValue({tag, ".pc"}, pc_d, e.pc8 - 32'd8);
      checkValue({tag, ".exc"}, {27'd0, exccode_d}, {27'd0, e.exc});
      checkValue({tag, ".bd"}, {31'd0, bd_d}, {31'd0, e.bd});
      checkValue({tag, ".valid"}, {31'd0, valid_d}, {31'd0, e.valid});
   endtask

   task automatic checkOutput(input string tag);
      slot_t e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s scoreboard empty actual=%0d required=1", tag, 0);
      end else begin
         e = expQ.pop_front();
         checkSlot(tag, e);
      end
   endtask

   // Reference behaviour of one rising edge
   function automatic slot_t nextSlot(input slot_t cur, input logic [31:0] ins, input logic [31:0] p8,
                                      input logic st, input logic irq, input logic er, input logic br);
      slot_t n;
      logic [31:0] pc;
      logic bad;
      pc  = p8 - 32'd8;
      bad = (pc[1:0] != 2'b00) || (pc < 32'h00003000) || (pc > 32'h00006FFC);
      if (irq)      n = '{instr: 32'd0, pc8: p8, exc: 5'd0, bd: 1'b0, valid: 1'b0};
      else if (st)  n = cur;
      else if (er)  n = '{instr: 32'd0, pc8: p8, exc: 5'd0, bd: 1'b0, valid: 1'b0};
      else if (bad) n = '{instr: 32'd0, pc8: p8, exc: 5'd4, bd: br, valid: 1'b1};
      else          n = '{instr: ins, pc8: p8, exc: 5'd0, bd: br, valid: 1'b1};
      return n;
   endfunction

   task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic [31:0] p8,
                                input logic st, input logic irq, input logic er, input logic br);
      @(negedge clk);
      instr_f  = ins;
      pc8_f    = p8;
      stall    = st;
      intreq   = irq;
      eret_d   = er;
      branch_d = br;
      model = nextSlot(model, ins, p8, st, irq, er, br);
      expQ.push_back(model);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      logic [31:0] picks [8];
      resetSlot = '{instr: 32'd0, pc8: 32'h00003008, exc: 5'd0, bd: 1'b0, valid: 1'b0};
      picks[0] = 32'h00003008; picks[1] = 32'h00003007; picks[2] = 32'h00007004; picks[3] = 32'h00007008;
      picks[4] = 32'h00003000; picks[5] = 32'h0000400C; picks[6] = 32'h0000500A; picks[7] = 32'h00000004;

      clr = 1'b0; instr_f = 32'hDEADBEEF; pc8_f = 32'h00004000;
      stall = 1'b0; intreq = 1'b0; eret_d = 1'b0; branch_d = 1'b0;
      model = resetSlot;
      repeat (3) @(posedge clk);
      #1;
      $display("[TB] checking reset hold");
      checkSlot("reset_hold", resetSlot);
      @(negedge clk);
      clr = 1'b1;

      // First load after reset
      applyStimulus("first_load", 32'h3C010001, 32'h00003008, 0, 0, 0, 0);

      // Asynchronous clear mid-cycle
      @(negedge clk);
      #2;
      clr = 1'b0;
      #1;
      model = resetSlot;
      checkSlot("async_clr", resetSlot);
      @(posedge clk);
      #1;
      checkSlot("clr_held", resetSlot);
      @(negedge clk);
      clr = 1'b1;

      // Load A then stall three cycles while fetch changes
      applyStimulus("slotA", 32'h24020005, 32'h00003010, 0, 0, 0, 0);
      applyStimulus("stall1", 32'h11111111, 32'h00003014, 1, 0, 0, 1);
      applyStimulus("stall2", 32'h22222222, 32'h00003018, 1, 0, 0, 1);
      applyStimulus("stall3", 32'h33333333, 32'h0000301C, 1, 0, 1, 0);
      applyStimulus("post_stall", 32'h44444444, 32'h00003020, 0, 0, 0, 0);

      // Branch delay slot, ERET bubble, flush overriding stall
      applyStimulus("bd_load", 32'h00851020, 32'h0000300C, 0, 0, 0, 1);
      applyStimulus("eret_bubble", 32'h55555555, 32'h00003010, 0, 0, 1, 1);
      applyStimulus("reload", 32'h66666666, 32'h00003014, 0, 0, 0, 0);
      applyStimulus("flush_stall", 32'h77777777, 32'h00003018, 1, 1, 1, 1);

      // Fetch address errors and boundaries
      applyStimulus("misaligned", 32'h88888888, 32'h0000300A, 0, 0, 0, 0);
      applyStimulus("above_hi", 32'h99999999, 32'h00007008, 0, 0, 0, 0);
      applyStimulus("at_hi", 32'hAAAAAAAA, 32'h00007004, 0, 0, 0, 0);
      applyStimulus("below_lo", 32'hBBBBBBBB, 32'h00003004, 0, 0, 0, 1);
      applyStimulus("wrap", 32'hCCCCCCCC, 32'h00000004, 0, 0, 0, 0);
      applyStimulus("stall_keeps_exc", 32'hDDDDDDDD, 32'h00003008, 1, 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 60; i++) begin
         applyStimulus("random", $urandom, picks[$urandom_range(0, 7)],
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
